// File: rtl/clarvi_mem_arbiter.sv
// Two-port arbiter sharing one 64-bit data memory port; one command in flight at a time.
// Define CLARVI_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: port 0 has priority).
module clarvi_mem_arbiter #(
  parameter int DATA_ADDR_WIDTH = 14
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req0_read,
  input  logic                       req0_write,
  input  logic [DATA_ADDR_WIDTH-1:0] req0_address,
  input  logic [7:0]                 req0_byte_enable,
  input  logic [63:0]                req0_write_data,
  output logic                       req0_ack,
  output logic [63:0]                req0_read_data,
  input  logic                       req1_read,
  input  logic                       req1_write,
  input  logic [DATA_ADDR_WIDTH-1:0] req1_address,
  input  logic [7:0]                 req1_byte_enable,
  input  logic [63:0]                req1_write_data,
  output logic                       req1_ack,
  output logic [63:0]                req1_read_data,
  output logic [DATA_ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]                 mem_byte_enable,
  output logic [63:0]                mem_write_data,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic                       mem_waitrequest,
  input  logic [63:0]                mem_read_data,
  input  logic                       mem_read_valid,
  output logic                       busy
);

  // state     | meaning
  // S_IDLE    | no command in flight, arbitrating
  // S_ISSUE   | strobe driven until memory accepts
  // S_WAIT    | read accepted, waiting for read data
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                     r_state, w_next;
  logic [DATA_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                 r_be;
  logic [63:0]                r_wdata;
  logic                       r_is_write;
  logic                       r_port;
  logic                       r_ack0, r_ack1;
  logic [63:0]                r_rdata0, r_rdata1;
  logic                       w_req0, w_req1, w_grant1, w_start, w_done;

  // A port being acked this cycle is masked so its still-held request is not re-granted.
  assign w_req0 = (req0_read | req0_write) & ~r_ack0;
  assign w_req1 = (req1_read | req1_write) & ~r_ack1;

`ifdef CLARVI_ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  assign w_grant1 = w_req1 & (~w_req0 | ~r_last_grant);
`else
  assign w_grant1 = w_req1 & ~w_req0;
`endif

  assign w_start = (r_state == S_IDLE) & (w_req0 | w_req1);
  assign w_done  = ((r_state == S_ISSUE) & ~mem_waitrequest & r_is_write) |
                   ((r_state == S_WAIT) & mem_read_valid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_ISSUE;
      S_ISSUE: if (!mem_waitrequest) w_next = r_is_write ? S_IDLE : S_WAIT;
      S_WAIT:  if (mem_read_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = (r_state == S_ISSUE) & ~r_is_write;
    mem_write = (r_state == S_ISSUE) & r_is_write;
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_port     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_ack0 <= w_done & ~r_port;
      r_ack1 <= w_done & r_port;
      if (w_start) begin
        r_port     <= w_grant1;
        r_addr     <= w_grant1 ? req1_address     : req0_address;
        r_be       <= w_grant1 ? req1_byte_enable : req0_byte_enable;
        r_wdata    <= w_grant1 ? req1_write_data  : req0_write_data;
        // read+write on one port is serviced as a write
        r_is_write <= w_grant1 ? req1_write       : req0_write;
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
        r_last_grant <= w_grant1;
`endif
      end
      if ((r_state == S_WAIT) && mem_read_valid) begin
        if (r_port) r_rdata1 <= mem_read_data;
        else        r_rdata0 <= mem_read_data;
      end
    end
  end

  assign mem_address     = r_addr;
  assign mem_byte_enable = r_be;
  assign mem_write_data  = r_wdata;
  assign req0_ack        = r_ack0;
  assign req1_ack        = r_ack1;
  assign req0_read_data  = r_rdata0;
  assign req1_read_data  = r_rdata1;

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed bench for clarvi_mem_arbiter: inputs driven 1ns after rising edge, outputs sampled on falling edge.
module tb_clarvi_mem_arbiter;
  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_read, req0_write, req1_read, req1_write;
  logic [AW-1:0] req0_address, req1_address;
  logic [7:0]    req0_byte_enable, req1_byte_enable;
  logic [63:0]   req0_write_data, req1_write_data;
  logic          req0_ack, req1_ack;
  logic [63:0]   req0_read_data, req1_read_data;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_byte_enable;
  logic [63:0]   mem_write_data;
  logic          mem_read, mem_write, mem_waitrequest, mem_read_valid, busy;
  logic [63:0]   mem_read_data;

  int n_chk = 0;
  int n_err = 0;
  int first;

  always #5 clock = ~clock;

  clarvi_mem_arbiter #(.DATA_ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req0_read(req0_read), .req0_write(req0_write), .req0_address(req0_address),
    .req0_byte_enable(req0_byte_enable), .req0_write_data(req0_write_data),
    .req0_ack(req0_ack), .req0_read_data(req0_read_data),
    .req1_read(req1_read), .req1_write(req1_write), .req1_address(req1_address),
    .req1_byte_enable(req1_byte_enable), .req1_write_data(req1_write_data),
    .req1_ack(req1_ack), .req1_read_data(req1_read_data),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clock); #1;
  endtask

  task automatic sm();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    req0_read = 0; req0_write = 0; req0_address = '0; req0_byte_enable = '0; req0_write_data = '0;
    req1_read = 0; req1_write = 0; req1_address = '0; req1_byte_enable = '0; req1_write_data = '0;
    mem_waitrequest = 0; mem_read_data = '0; mem_read_valid = 0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_address, 0);
    check("rst_ack0", req0_ack, 0);
    check("rst_rdata1", req1_read_data, 0);
    adv(); adv(); reset = 1'b1;

    // single write from port 0, held one cycle past its ack
    adv(); req0_write = 1; req0_address = 14'h010; req0_byte_enable = 8'hFF;
    req0_write_data = 64'h1122334455667788;
    sm(); check("w_c0_busy", busy, 0);
    adv(); sm();
    check("w_c1_mem_write", mem_write, 1);
    check("w_c1_addr", mem_address, 14'h010);
    check("w_c1_be", mem_byte_enable, 8'hFF);
    check("w_c1_data", mem_write_data, 64'h1122334455667788);
    check("w_c1_ack0", req0_ack, 0);
    adv(); sm();
    check("w_c2_ack0", req0_ack, 1);
    check("w_c2_mem_write", mem_write, 0);
    check("w_c2_busy", busy, 0);
    adv(); req0_write = 0; sm();
    check("w_c3_ack0", req0_ack, 0);
    check("w_c3_busy", busy, 0);
    check("w_c3_mem_write", mem_write, 0);

    // both ports write at once; last grant was port 0
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
    first = 1;
`else
    first = 0;
`endif
    adv();
    req0_write = 1; req0_address = 14'h100; req0_byte_enable = 8'h0F; req0_write_data = 64'hAAAA0000AAAA0000;
    req1_write = 1; req1_address = 14'h200; req1_byte_enable = 8'hF0; req1_write_data = 64'hBBBB1111BBBB1111;
    adv(); sm();
    check("arb_c1_addr", mem_address, first ? 14'h200 : 14'h100);
    check("arb_c1_data", mem_write_data, first ? 64'hBBBB1111BBBB1111 : 64'hAAAA0000AAAA0000);
    adv(); sm();
    check("arb_c2_ack0", req0_ack, first == 0);
    check("arb_c2_ack1", req1_ack, first == 1);
    adv(); if (first == 0) req0_write = 0; else req1_write = 0; sm();
    check("arb_c3_mem_write", mem_write, 1);
    check("arb_c3_addr", mem_address, first ? 14'h100 : 14'h200);
    check("arb_c3_be", mem_byte_enable, first ? 8'h0F : 8'hF0);
    adv(); req0_write = 0; req1_write = 0; sm();
    check("arb_c4_ack0", req0_ack, first == 1);
    check("arb_c4_ack1", req1_ack, first == 0);
    adv(); sm();
    check("arb_c5_busy", busy, 0);

    // port 1 read with three stalled cycles
    adv(); req1_read = 1; req1_address = 14'h3FFF; mem_waitrequest = 1;
    sm();
    for (int c = 1; c <= 4; c++) begin
      adv(); if (c == 4) mem_waitrequest = 0; sm();
      check("rd_stall_mem_read", mem_read, 1);
      check("rd_stall_addr", mem_address, 14'h3FFF);
    end
    adv(); sm();
    check("rd_c5_mem_read", mem_read, 0);
    check("rd_c5_busy", busy, 1);
    adv(); mem_read_valid = 1; mem_read_data = 64'hDEADBEEF00000000; sm();
    check("rd_c6_ack1", req1_ack, 0);
    adv(); mem_read_valid = 0; req1_read = 0; sm();
    check("rd_c7_ack1", req1_ack, 1);
    check("rd_c7_ack0", req0_ack, 0);
    check("rd_c7_data", req1_read_data, 64'hDEADBEEF00000000);
    check("rd_c7_busy", busy, 0);
    adv(); sm();
    check("rd_c8_ack1", req1_ack, 0);
    check("rd_c8_hold", req1_read_data, 64'hDEADBEEF00000000);
    check("rd_c8_rdata0", req0_read_data, 0);

    // stray read_valid while idle
    adv(); mem_read_valid = 1; mem_read_data = 64'hFFFFFFFFFFFFFFFF; sm();
    adv(); mem_read_valid = 0; sm();
    check("stray_ack1", req1_ack, 0);
    check("stray_hold", req1_read_data, 64'hDEADBEEF00000000);

    // reset while waiting for read data
    adv(); req0_read = 1; req0_address = 14'h055; req0_byte_enable = 8'h01;
    adv(); adv(); sm();
    check("rstrd_wait_busy", busy, 1);
    reset = 0; req0_read = 0; #1;
    check("rstrd_busy", busy, 0);
    check("rstrd_addr", mem_address, 0);
    check("rstrd_rdata1", req1_read_data, 0);
    adv(); reset = 1; mem_read_valid = 1; mem_read_data = 64'h1234; sm();
    adv(); mem_read_valid = 0; sm();
    check("rstrd_ack0", req0_ack, 0);
    check("rstrd_rdata0", req0_read_data, 0);
    check("rstrd_busy2", busy, 0);
    adv(); req0_write = 1; req0_read = 1; req0_address = 14'h007; req0_write_data = 64'hC0FFEE;
    req0_byte_enable = 8'h3C;
    adv(); sm();
    check("post_mem_write", mem_write, 1);
    check("post_mem_read", mem_read, 0);
    check("post_addr", mem_address, 14'h007);
    adv(); req0_write = 0; req0_read = 0; sm();
    check("post_ack0", req0_ack, 1);
    adv(); sm();
    check("post_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
